// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data memory with clear-on-reset and registered response
// Ports: clk/rst (async, active-high); req_* valid/ready request (write, size, signed, addr, wdata);
//        rsp_valid/rsp_rdata/rsp_err one-cycle registered response; busy while the array is being cleared.
module data_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int LW = $clog2(DATA_W / 8);
    localparam int IW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] M8  = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] M16 = DATA_W'(16'hFFFF);

    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;

    logic [IW-1:0]            cnt;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [LW-1:0]            lane;
    logic [IW-1:0]            idx;
    logic [$clog2(DATA_W)-1:0] bsh;
    logic [DATA_W-1:0]        mask, wmask, sh, rd;
    logic                     err, acc, msb, hi;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= CLEAR;
        else     state <= state_nx;

    always_comb state_nx = (state == CLEAR && &cnt) ? RUN : state;

    always_comb begin
        busy      = state == CLEAR;
        req_ready = state == RUN;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)                 cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;

    always_comb begin
        lane  = req_addr[LW-1:0];
        idx   = req_addr[LW +: IW];
        bsh   = {lane, 3'b000};
        // any address bit above the word-index field means the index is out of range
        hi    = |(req_addr >> (LW + IW));
        err   = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && |lane) || hi;
        acc   = req_valid && req_ready;
        mask  = req_size == 2'd0 ? M8 : req_size == 2'd1 ? M16 : '1;
        wmask = mask << bsh;
        sh    = mem[idx] >> bsh;
        msb   = req_size == 2'd0 ? sh[7] : sh[15];
        // for word loads mask is all ones, so the extension term vanishes
        rd    = (sh & mask) | ({DATA_W{req_signed && msb}} & ~mask);
    end

    always_ff @(posedge clk)
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (acc && req_write && !err)
            mem[idx] <= (mem[idx] & ~wmask) | ((req_wdata << bsh) & wmask);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= acc;
            rsp_err   <= acc && err;
            rsp_rdata <= (acc && !err && !req_write) ? rd : '0;
        end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl with directed vectors
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd2;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int vectors = 0, miscompares = 0;
    logic [32:0] exp_q[$];

    data_memory_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [32:0] act, input logic [32:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", {rsp_err, rsp_rdata}, 33'h1_FFFF_FFFF);
            else chk("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
        end

    task automatic issue(input logic w, input logic [1:0] s, input logic sg, input logic [15:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        req_valid = 1'b1; req_write = w; req_size = s; req_signed = sg; req_addr = a; req_wdata = wd;
        exp_q.push_back({ee, ed});
        @(posedge clk); #1;
    endtask

    task automatic wait_clear(input string n);
        int c = 0;
        while (busy && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk(n, 33'(c), 33'd256);
        chk({n, "_ready"}, 33'(req_ready), 33'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", 33'(req_ready), 33'd0);
        chk("rst_busy", 33'(busy), 33'd1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 33'h0);
        // a store held during the clear phase must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk); rst = 1'b0;
        wait_clear("clear_cycles");
        req_valid = 1'b0;
        issue(0, 2'd2, 0, 16'h0000, 0, 32'h0, 0);
        issue(0, 2'd2, 0, 16'h0080, 0, 32'h0, 0);
        issue(1, 2'd2, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 2'd0, 1, 16'h0010, 0, 32'hFFFFFFEF, 0);
        issue(0, 2'd0, 1, 16'h0011, 0, 32'hFFFFFFBE, 0);
        issue(0, 2'd0, 1, 16'h0012, 0, 32'hFFFFFFAD, 0);
        issue(0, 2'd0, 1, 16'h0013, 0, 32'hFFFFFFDE, 0);
        issue(0, 2'd0, 0, 16'h0013, 0, 32'h000000DE, 0);
        issue(0, 2'd1, 0, 16'h0012, 0, 32'h0000DEAD, 0);
        issue(1, 2'd2, 0, 16'h0020, 32'h11223344, 32'h0, 0);
        issue(1, 2'd1, 0, 16'h0022, 32'h0000AB80, 32'h0, 0);
        issue(0, 2'd2, 0, 16'h0020, 0, 32'hAB803344, 0);
        issue(0, 2'd1, 1, 16'h0022, 0, 32'hFFFFAB80, 0);
        issue(1, 2'd2, 0, 16'h0021, 32'h55555555, 32'h0, 1);
        issue(0, 2'd2, 0, 16'h0020, 0, 32'hAB803344, 0);
        issue(0, 2'd1, 0, 16'h0023, 0, 32'h0, 1);
        issue(0, 2'd3, 0, 16'h0020, 0, 32'h0, 1);
        issue(0, 2'd2, 0, 16'h0400, 0, 32'h0, 1);
        issue(1, 2'd2, 0, 16'h0400, 32'h12345678, 32'h0, 1);
        issue(0, 2'd2, 0, 16'h0000, 0, 32'h0, 0);
        issue(1, 2'd0, 0, 16'h0021, 32'h0000007F, 32'h0, 0);
        issue(0, 2'd2, 0, 16'h0020, 0, 32'hAB807F44, 0);
        issue(0, 2'd0, 1, 16'h0021, 0, 32'h0000007F, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", 33'(rsp_valid), 33'd0);
        issue(1, 2'd2, 0, 16'h0004, 32'h0000CAFE, 32'h0, 0);
        chk("b2b_valid0", 33'(rsp_valid), 33'd1);
        issue(0, 2'd2, 0, 16'h0004, 0, 32'h0000CAFE, 0);
        chk("b2b_valid1", 33'(rsp_valid), 33'd1);
        issue(0, 2'd2, 0, 16'h0008, 0, 32'h0, 0);
        chk("b2b_valid2", 33'(rsp_valid), 33'd1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end", 33'(rsp_valid), 33'd0);
        // load accepted, then reset before its response is sampled: it must vanish
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 16'h0004;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("midrst_valid", 33'(rsp_valid), 33'd0);
        chk("midrst_busy", 33'(busy), 33'd1);
        @(negedge clk); rst = 1'b0;
        wait_clear("reclear_cycles");
        issue(0, 2'd2, 0, 16'h0004, 0, 32'h0, 0);
        issue(0, 2'd2, 0, 16'h0020, 0, 32'h0, 0);
        issue(0, 2'd2, 0, 16'h0010, 0, 32'h0, 0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 33'(exp_q.size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
